// File: rtl/prog_loader.sv
// Boot loader: assembles UART bytes into words and writes instruction memory.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module prog_loader #(
    parameter int               WIDTH     = 32,
    parameter int               ADDR_W    = 10,
    parameter logic [WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [7:0]       CMD_LOAD  = 8'h4C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              cpu_stop,
    output logic              pc_reset,
    output logic              load_done,
    output logic              load_ovf,
    output logic [ADDR_W:0]   word_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic              load_err
`endif
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_DONE, S_CKSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_RECV, S_WRITE, S_DONE
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_acc;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_ovf;
    logic              w_cmd;
    logic              w_take;
    logic              w_last;
    logic              w_halt;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
    logic              r_err;
    logic              w_bad;
`endif

    assign w_last = &r_addr;
    assign w_halt = (r_acc == HALT_WORD);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        imem_we  = 1'b0;
        cpu_stop = 1'b0;
        pc_reset = 1'b0;
        w_cmd    = 1'b0;
        w_take   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_bad    = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (rx_done && rx_data == CMD_LOAD) begin
                    w_cmd  = 1'b1;
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                cpu_stop = 1'b1;
                w_take   = rx_done;
                if (rx_done && r_idx == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                imem_we  = 1'b1;
                cpu_stop = 1'b1;
                if (w_halt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next = S_CKSUM;
`else
                    w_next = S_DONE;
`endif
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    // a byte landing here starts the next word
                    w_next = S_RECV;
                    w_take = rx_done;
                end
            end
            S_DONE: begin
                cpu_stop = 1'b1;
                pc_reset = 1'b1;
                w_next   = S_IDLE;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                cpu_stop = 1'b1;
                if (rx_done) begin
                    if (rx_data == r_xor) begin
                        w_next = S_DONE;
                    end else begin
                        w_bad  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            if (w_cmd) begin
                r_idx   <= '0;
                r_addr  <= '0;
                r_count <= '0;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_xor   <= '0;
                r_err   <= 1'b0;
`endif
            end
            if (w_take) begin
                r_acc[{r_idx, 3'b000} +: 8] <= rx_data;
                r_idx <= r_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_xor <= r_xor ^ rx_data;
`endif
            end
            if (imem_we) begin
                r_count <= r_count + CNT_ONE;
                // the last address saturates; a halt there is not overflow
                if (!w_last)     r_addr <= r_addr + ADDR_ONE;
                else if (!w_halt) r_ovf <= 1'b1;
            end
            if (pc_reset) r_done <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            if (w_bad) r_err <= 1'b1;
`endif
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_acc;
    assign word_count = r_count;
    assign load_done  = r_done;
    assign load_ovf   = r_ovf;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign load_err   = r_err;
`endif

endmodule
